// File: rtl/mix_columns_engine.sv
// mix_columns_engine
//   Sequential AES MixColumns / InvMixColumns engine for the iterative round
//   core. A 128-bit state is accepted on a valid/ready handshake, mixed
//   COLS_PER_CYCLE columns per clock in ascending column order, and presented
//   on a valid/ready output handshake. The mode is latched at acceptance.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_state [127:0]      input state, column c at [c*32 +: 32], row 0 = top byte
//   in_inverse            0 = forward MixColumns, 1 = InvMixColumns
//   out_valid / out_ready output handshake
//   out_state [127:0]     mixed state, same byte layout as in_state
//   busy                  engine is not idle
module mix_columns_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned K     = COLS_PER_CYCLE;
    localparam int unsigned P     = 4 / K;
    localparam int unsigned CNT_W = 2;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_d;
    logic [127:0]       work, work_d, mixed, out_state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               mode, mode_d;

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Mix one column; coefficients are built from chained xtime stages.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] b  [4];
        logic [1:0] r1, r2, r3;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[(3-r)*8 +: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            r1 = 2'(r + 1);
            r2 = 2'(r + 2);
            r3 = 2'(r + 3);
            if (inv) begin
                // 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3]
                b[r] = (x8[r] ^ x4[r] ^ x2[r])
                     ^ (x8[r1] ^ x2[r1] ^ a[r1])
                     ^ (x8[r2] ^ x4[r2] ^ a[r2])
                     ^ (x8[r3] ^ a[r3]);
            end else begin
                // 02*a[r] ^ 03*a[r+1] ^ a[r+2] ^ a[r+3]
                b[r] = x2[r] ^ (x2[r1] ^ a[r1]) ^ a[r2] ^ a[r3];
            end
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Working register with the current column group replaced by its mix.
    always_comb begin : mix_group
        mixed = work;
        for (int unsigned k = 0; k < K; k++) begin
            mixed[(32'(cnt) * K + k) * 32 +: 32] = mix_col(work[(32'(cnt) * K + k) * 32 +: 32], mode);
        end
    end

    // Next-state and datapath control.
    always_comb begin : next_state
        state_d     = state;
        work_d      = work;
        cnt_d       = cnt;
        mode_d      = mode;
        out_state_d = out_state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    work_d  = in_state;
                    mode_d  = in_inverse;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                work_d = mixed;
                cnt_d  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(P - 1)) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    // Only the fully mixed state ever reaches out_state.
                    out_state_d = mixed;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            out_state <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            work      <= work_d;
            cnt       <= cnt_d;
            mode      <= mode_d;
            out_state <= out_state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine
//   Runs three engines (COLS_PER_CYCLE = 1, 2, 4) side by side on the same
//   stimulus: directed AES vectors, backpressure, mode latching, mid-run
//   reset, and random states checked against a shift-and-add GF model plus
//   forward/inverse round trips.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_inverse = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic [2:0]   rdy, ov, bsy;
    logic [127:0] os [3];

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] V_IN  = 128'h2d26314c_01010101_f20a225c_db135345;
    localparam logic [127:0] V_OUT = 128'h4d7ebdf8_01010101_9fdc589d_8e4da1bc;

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_k1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_state(in_state), .in_inverse(in_inverse), .out_valid(ov[0]),
        .out_ready(out_ready), .out_state(os[0]), .busy(bsy[0]));
    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_k2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_state(in_state), .in_inverse(in_inverse), .out_valid(ov[1]),
        .out_ready(out_ready), .out_state(os[1]), .busy(bsy[1]));
    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_k4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_state(in_state), .in_inverse(in_inverse), .out_valid(ov[2]),
        .out_ready(out_ready), .out_state(os[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_exp(input int j);
        return (j == 0) ? 4 : (j == 1) ? 2 : 1;
    endfunction

    // Reference: generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? (8'({aa[6:0], 1'b0}) ^ 8'h1b) : 8'({aa[6:0], 1'b0});
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input logic inv, input int d);
        case (d)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] st, input logic inv);
        logic [127:0] res = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int cc = 0; cc < 4; cc++)
                    acc = acc ^ gmul(coef(inv, (cc - r + 4) % 4), st[c*32 + (3-cc)*8 +: 8]);
                res[c*32 + (3-r)*8 +: 8] = acc;
            end
        end
        return res;
    endfunction

    // One transaction on all three engines; in_inverse is flipped right after
    // acceptance and a stray in_valid is pulsed while the result is stalled.
    task automatic run_txn(input logic [127:0] st, input logic inv, input int stall,
                           input logic [127:0] exp, output logic [127:0] res);
        int seen_at [3];
        check("idle_ready", 128'(rdy), 128'(3'b111));
        in_valid   = 1'b1;
        in_state   = st;
        in_inverse = inv;
        out_ready  = 1'b0;
        @(negedge clk);
        in_valid   = 1'b0;
        in_inverse = ~inv;
        in_state   = ~st;
        check("run_ready_low", 128'(rdy), 128'(3'b000));
        check("run_busy", 128'(bsy), 128'(3'b111));
        seen_at = '{0, 0, 0};
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++)
                if (ov[j] && seen_at[j] == 0) seen_at[j] = cyc;
        end
        for (int j = 0; j < 3; j++) begin
            check($sformatf("latency_k%0d", j), 128'(seen_at[j]), 128'(lat_exp(j)));
            check($sformatf("result_k%0d", j), os[j], exp);
        end
        check("done_ready_low", 128'(rdy), 128'(3'b000));
        for (int s = 0; s < stall; s++) begin
            in_valid = (s == stall / 2);
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("stall_valid", 128'(ov), 128'(3'b111));
            check("stall_ready_low", 128'(rdy), 128'(3'b000));
            check("stall_hold_k1", os[0], exp);
        end
        in_valid  = 1'b0;
        res       = os[0];
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid_low", 128'(ov), 128'(3'b000));
        check("post_ready", 128'(rdy), 128'(3'b111));
        check("post_busy_low", 128'(bsy), 128'(3'b000));
    endtask

    initial begin
        logic [127:0] r, f, b, st;
        int stall;

        repeat (3) @(negedge clk);
        check("rst_valid", 128'(ov), 128'(3'b000));
        check("rst_busy", 128'(bsy), 128'(3'b000));
        for (int j = 0; j < 3; j++) check("rst_out_state", os[j], 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 128'(rdy), 128'(3'b111));

        run_txn(V_IN, 1'b0, 0, V_OUT, r);
        run_txn(V_OUT, 1'b1, 0, V_IN, r);
        // Backpressure with a stray in_valid in DONE.
        run_txn(V_IN, 1'b0, 10, V_OUT, r);
        // Mode latch: inverse accepted, in_inverse driven low during RUN.
        run_txn(V_OUT, 1'b1, 2, V_IN, r);

        // Asynchronous reset two cycles into a K=1 run.
        in_valid = 1'b1; in_state = V_IN; in_inverse = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 128'(ov), 128'(3'b000));
        check("arst_busy", 128'(bsy), 128'(3'b000));
        for (int j = 0; j < 3; j++) check("arst_out_state", os[j], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_ready", 128'(rdy), 128'(3'b111));
        check("arst_release_valid", 128'(ov), 128'(3'b000));
        run_txn(V_OUT, 1'b1, 0, V_IN, r);
        run_txn(V_IN, 1'b0, 0, V_OUT, r);

        for (int i = 0; i < 1000; i++) begin
            st    = {$urandom, $urandom, $urandom, $urandom};
            stall = int'($urandom_range(0, 3));
            if (i % 2 == 0) begin
                run_txn(st, 1'b0, stall, model_mix(st, 1'b0), f);
                run_txn(f, 1'b1, int'($urandom_range(0, 3)), st, b);
            end else begin
                run_txn(st, 1'b1, stall, model_mix(st, 1'b1), f);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
